// File: rtl/register_file.sv
// register_file: 32x32 RISC-V integer register file, two async read ports, one sync write port
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] SP_INIT = 32'h7FFF_EFFC,
  parameter logic [DATA_WIDTH-1:0] GP_INIT = 32'h1000_8000,
  parameter bit BYPASS = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [ADDR_WIDTH-1:0] Write_Register_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic wr_en;
  assign wr_en = Reg_Write_i && Write_Register_i != '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i == 2) ? SP_INIT : (i == 3) ? GP_INIT : '0;
    else if (wr_en)
      mem[Write_Register_i] <= Write_Data_i;
  // forwarding is suppressed while reset is held so reads show the reset contents
  always_comb begin
    Read_Data_1_o = (Read_Register_1_i == '0) ? '0 :
                    (BYPASS && reset && wr_en && Write_Register_i == Read_Register_1_i) ? Write_Data_i :
                    mem[Read_Register_1_i];
    Read_Data_2_o = (Read_Register_2_i == '0) ? '0 :
                    (BYPASS && reset && wr_en && Write_Register_i == Read_Register_2_i) ? Write_Data_i :
                    mem[Read_Register_2_i];
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed + random checks of both bypass modes against an array model
module tb_register_file;
  localparam logic [31:0] SP = 32'h7FFF_EFFC;
  localparam logic [31:0] GP = 32'h1000_8000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, we;
  logic [4:0] wa, ra1, ra2;
  logic [31:0] wd, q1a, q2a, q1b, q2b;
  logic [31:0] model [32];
  int checks = 0, failures = 0;

  register_file #(.BYPASS(1'b0)) dut_a (
    .clk(clk), .reset(reset), .Reg_Write_i(we), .Write_Register_i(wa), .Write_Data_i(wd),
    .Read_Register_1_i(ra1), .Read_Register_2_i(ra2), .Read_Data_1_o(q1a), .Read_Data_2_o(q2a));
  register_file #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .Reg_Write_i(we), .Write_Register_i(wa), .Write_Data_i(wd),
    .Read_Register_1_i(ra1), .Read_Register_2_i(ra2), .Read_Data_1_o(q1b), .Read_Data_2_o(q2b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (model[i]) model[i] = '0;
    model[2] = SP;
    model[3] = GP;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit byp);
    if (idx == 0) return '0;
    if (byp && reset === 1'b1 && we && wa == idx) return wd;
    return model[idx];
  endfunction

  task automatic check_reads(input string tag);
    check({tag, "_a1"}, q1a, exp_rd(ra1, 1'b0));
    check({tag, "_a2"}, q2a, exp_rd(ra2, 1'b0));
    check({tag, "_b1"}, q1b, exp_rd(ra1, 1'b1));
    check({tag, "_b2"}, q2b, exp_rd(ra2, 1'b1));
  endtask

  task automatic edge_update();
    @(posedge clk);
    if (reset && we && wa != 0) model[wa] = wd;
    #1;
  endtask

  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
    #1 check_reads("pre");
    edge_update();
    check_reads("post");
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd2; ra2 = 5'd3;
    model_reset();
    @(posedge clk); #1;
    check("rst_sp", q1a, 32'h7FFFEFFC);
    check("rst_gp", q2a, 32'h10008000);
    check("rst_sp_b", q1b, 32'h7FFFEFFC);
    ra1 = 5'd5; #1;
    check("rst_x5", q1a, 32'h0);
    @(negedge clk) reset = 1'b1;
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    check("wr_x5_p1", q1a, 32'hDEADBEEF);
    check("wr_x5_p2", q2a, 32'hDEADBEEF);
    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    check("wr_x0_a", q1a, 32'h0);
    check("wr_x0_b", q1b, 32'h0);
    repeat (3) cyc(1'b0, 5'd7, 32'h1234, 5'd7, 5'd7);
    check("no_we_x7", q1a, 32'h0);
    cyc(1'b1, 5'd9, 32'h11, 5'd1, 5'd2);
    @(negedge clk);
    we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5; ra1 = 5'd9; ra2 = 5'd9;
    #1;
    check("rdw_a_pre", q1a, 32'h11);
    check("rdw_b_pre", q1b, 32'hA5A5A5A5);
    edge_update();
    check("rdw_a_post", q1a, 32'hA5A5A5A5);
    check("rdw_b_post", q1b, 32'hA5A5A5A5);
    cyc(1'b1, 5'd10, 32'h55, 5'd10, 5'd10);
    @(negedge clk);
    we = 1'b1; wa = 5'd10; wd = 32'h99; ra1 = 5'd10; ra2 = 5'd2;
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("async_a", q1a, 32'h0);
    check("async_b", q1b, 32'h0);
    check_reads("async");
    edge_update();
    check("held_wr", q1a, 32'h0);
    check_reads("held");
    wa = 5'd12; wd = 32'hCAFE; ra1 = 5'd12; ra2 = 5'd10;
    @(negedge clk) reset = 1'b1;
    #1 check_reads("rel_pre");
    edge_update();
    check("rel_first_wr", q1a, 32'hCAFE);
    check_reads("rel_post");
    repeat (400) begin
      logic [4:0] a, r1, r2;
      a = 5'($urandom);
      r1 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), a, $urandom, r1, r2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
